// File: rtl/md5_iter_core.sv
// Iterative MD5 compression core: one 512-bit block per pass, STEPS rounds per clock,
// with chaining across blocks and a valid/ready digest output.
module md5_iter_core #(
    parameter int STEPS   = 1,
    parameter int OUT_REG = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [511:0] blk_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] hash_o,
    output logic         busy_o,
    output logic [1:0]   state_o
);

    if (!(STEPS == 1 || STEPS == 2 || STEPS == 4 || STEPS == 8 || STEPS == 16)) begin : g_bad_steps
        $error("md5_iter_core: STEPS must be 1, 2, 4, 8 or 16");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid_o never drops before its transfer, in_ready_o is high only when idle.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ADD = 2'd2, DONE = 2'd3} state_t;

    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotation amounts repeat every four steps within a round: index {round, step[1:0]}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [127:0] md5_step(input logic [127:0] abcd, input logic [5:0] idx,
                                              input logic [511:0] m);
        logic [31:0] a, b, c, d, f, t, rot;
        logic [3:0]  g;
        logic [4:0]  s;
        {a, b, c, d} = abcd;
        case (idx[5:4])
            2'd0: begin f = (b & c) | (~b & d); g = idx[3:0]; end
            2'd1: begin f = (d & b) | (~d & c); g = idx[3:0] * 4'd5 + 4'd1; end
            2'd2: begin f = b ^ c ^ d;          g = idx[3:0] * 4'd3 + 4'd5; end
            default: begin f = c ^ (b | ~d);    g = idx[3:0] * 4'd7; end
        endcase
        s   = S_TAB[{idx[5:4], idx[1:0]}];
        t   = a + f + K_TAB[idx] + m[32*g +: 32];
        rot = (t << s) | (t >> (6'd32 - {1'b0, s}));
        return {d, b + rot, b, c};
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    state_t         state, state_nxt;
    logic [127:0]   chain, work, stage;
    logic [511:0]   blk_q;
    logic           last_q;
    logic [5:0]     cnt, cnt_nxt;
    logic [127:0]   digest;

    assign cnt_nxt    = cnt + 6'(STEPS);
    assign in_ready_o = (state == IDLE);
    assign busy_o     = (state != IDLE);
    assign state_o    = state;
    assign digest     = {bswap(chain[127:96]), bswap(chain[95:64]),
                         bswap(chain[63:32]), bswap(chain[31:0])};

    always_comb begin
        stage = work;
        for (int k = 0; k < STEPS; k++) begin
            stage = md5_step(stage, cnt + 6'(k), blk_q);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid_i) state_nxt = RUN;
            RUN:     if (cnt_nxt == 6'd0) state_nxt = ADD;
            ADD:     state_nxt = last_q ? DONE : IDLE;
            default: if (out_valid_o && out_ready_i) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            chain  <= IV;
            work   <= '0;
            blk_q  <= '0;
            last_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid_i) begin
                    blk_q  <= blk_i;
                    last_q <= last_i;
                    cnt    <= '0;
                    if (first_i) begin
                        chain <= IV;
                        work  <= IV;
                    end else begin
                        work  <= chain;
                    end
                end
                RUN: begin
                    work <= stage;
                    cnt  <= cnt_nxt;
                end
                ADD: chain <= {chain[127:96] + work[127:96], chain[95:64] + work[95:64],
                               chain[63:32] + work[63:32],   chain[31:0] + work[31:0]};
                default: ;
            endcase
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic         ov_q;
        logic [127:0] hash_q;
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                ov_q   <= 1'b0;
                hash_q <= '0;
            end else if (state == DONE && !ov_q) begin
                ov_q   <= 1'b1;
                hash_q <= digest;
            end else if (ov_q && out_ready_i) begin
                ov_q   <= 1'b0;
            end
        end
        assign out_valid_o = ov_q;
        assign hash_o      = hash_q;
    end else begin : g_out_comb
        assign out_valid_o = (state == DONE);
        assign hash_o      = (state == DONE) ? digest : '0;
    end

endmodule

// File: tb/tb_md5_iter_core.sv
// Bench for md5_iter_core: three configurations checked against RFC 1321 vectors
// and a behavioural MD5 model over random multi-block messages.
module tb_md5_iter_core;

    localparam int N = 3;
    localparam int ST_TAB [N] = '{1, 4, 16};
    localparam int OR_TAB [N] = '{0, 1, 0};
    localparam logic [127:0] IV_M = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam int SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

    localparam logic [127:0] H_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] H_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] H_DIG80 = 128'h57edf4a22be3c955ac49da2e2107b67a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid [N];
    logic         in_ready [N];
    logic         first [N];
    logic         last [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic         busy [N];
    logic [511:0] blk [N];
    logic [127:0] hash [N];
    logic [1:0]   state [N];

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  k_tab [64];
    logic [127:0] chain_m [N];
    logic [511:0] msg_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        md5_iter_core #(.STEPS(ST_TAB[g]), .OUT_REG(OR_TAB[g])) u_dut (
            .clk_i(clk), .rst_i(rst_n),
            .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
            .blk_i(blk[g]), .first_i(first[g]), .last_i(last[g]),
            .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
            .hash_o(hash[g]), .busy_o(busy[g]), .state_o(state[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // MD5 compression function including the feed-forward addition into the chain.
    function automatic logic [127:0] compress(input logic [127:0] h, input logic [511:0] m);
        int unsigned a, b, c, d, f, g, t, s, tmp;
        a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            s   = SH[i / 16][i % 4];
            t   = a + f + k_tab[i] + m[32*g +: 32];
            tmp = d; d = c; c = b;
            b   = b + ((t << s) | (t >> (32 - s)));
            a   = tmp;
        end
        return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
    endfunction

    function automatic logic [127:0] to_digest(input logic [127:0] h);
        logic [127:0] o;
        logic [31:0]  w;
        for (int i = 0; i < 4; i++) begin
            w = h[127 - 32*i -: 32];
            for (int j = 0; j < 4; j++) o[127 - 8*(4*i + j) -: 8] = w[8*j +: 8];
        end
        return o;
    endfunction

    // Pads a byte string into 512-bit blocks, byte p of a block at bits [8p+7:8p].
    task automatic build(input string s);
        int     len, nblk, idx;
        longint bits;
        logic [511:0] w;
        logic [7:0]   v;
        msg_q.delete();
        len  = s.len();
        nblk = (len + 8) / 64 + 1;
        bits = longint'(len) * 8;
        for (int b = 0; b < nblk; b++) begin
            w = '0;
            for (int p = 0; p < 64; p++) begin
                idx = 64 * b + p;
                if (idx < len) v = s[idx];
                else if (idx == len) v = 8'h80;
                else if (idx >= 64 * nblk - 8) v = 8'(bits >> (8 * (idx - (64 * nblk - 8))));
                else v = 8'h00;
                w[8*p +: 8] = v;
            end
            msg_q.push_back(w);
        end
    endtask

    task automatic accept(input int d, input logic [511:0] b, input logic f, input logic l,
                          input string tag);
        int n = 0;
        while (!in_ready[d] && n < 300) begin tick(); n++; end
        check({tag, " ready"}, 128'(in_ready[d]), 128'(1));
        in_valid[d] = 1'b1; blk[d] = b; first[d] = f; last[d] = l;
        tick();
        in_valid[d] = 1'b0; blk[d] = rand_blk();
        first[d] = 1'($urandom_range(0, 1)); last[d] = 1'($urandom_range(0, 1));
        if (f) chain_m[d] = IV_M;
        chain_m[d] = compress(chain_m[d], b);
    endtask

    task automatic expect_mid(input int d, input string tag);
        int   n = 0;
        logic bad = 1'b0;
        while (!in_ready[d] && n < 300) begin
            if (out_valid[d]) bad = 1'b1;
            tick(); n++;
        end
        check({tag, " no_out"}, 128'(bad), 128'(0));
        check({tag, " cycles"}, 128'(n), 128'(64 / ST_TAB[d] + 1));
    endtask

    task automatic expect_digest(input int d, input logic [127:0] exp, input int hold,
                                 input string tag);
        int n = 0;
        while (!out_valid[d] && n < 300) begin tick(); n++; end
        check({tag, " latency"}, 128'(n), 128'(64 / ST_TAB[d] + 1 + OR_TAB[d]));
        check({tag, " hash"}, hash[d], exp);
        check({tag, " ready_low"}, 128'(in_ready[d]), 128'(0));
        for (int h = 0; h < hold; h++) begin
            out_ready[d] = 1'b0; in_valid[d] = 1'b1; blk[d] = rand_blk();
            first[d] = 1'b1; last[d] = 1'b1;
            tick();
            check({tag, " hold_valid"}, 128'(out_valid[d]), 128'(1));
            check({tag, " hold_hash"}, hash[d], exp);
            check({tag, " hold_ready"}, 128'(in_ready[d]), 128'(0));
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check({tag, " post_valid"}, 128'(out_valid[d]), 128'(0));
        check({tag, " post_ready"}, 128'(in_ready[d]), 128'(1));
        check({tag, " post_busy"}, 128'(busy[d]), 128'(0));
    endtask

    task automatic send_msg(input int d, input logic f0, input int hold, input string tag);
        for (int i = 0; i < msg_q.size(); i++) begin
            accept(d, msg_q[i], (i == 0) ? f0 : 1'b0, i == msg_q.size() - 1, tag);
            if (i != msg_q.size() - 1) expect_mid(d, tag);
        end
        expect_digest(d, to_digest(chain_m[d]), hold, tag);
    endtask

    initial begin
        real x;
        int  nb;
        for (int i = 0; i < 64; i++) begin
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            k_tab[i] = 32'(longint'($floor(4294967296.0 * x)));
        end
        for (int d = 0; d < N; d++) begin
            in_valid[d] = 1'b0; first[d] = 1'b0; last[d] = 1'b0;
            out_ready[d] = 1'b0; blk[d] = '0; chain_m[d] = IV_M;
        end

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < N; d++) begin
            check("rst in_ready", 128'(in_ready[d]), 128'(1));
            check("rst out_valid", 128'(out_valid[d]), 128'(0));
            check("rst busy", 128'(busy[d]), 128'(0));
            check("rst hash", hash[d], 128'(0));
        end

        // Empty message with long backpressure, then "abc" back to back on the same core.
        build("");
        check("empty vec model", to_digest(compress(IV_M, msg_q[0])), H_EMPTY);
        accept(0, msg_q[0], 1'b1, 1'b1, "empty");
        expect_digest(0, H_EMPTY, 20, "empty");
        build("abc");
        accept(0, msg_q[0], 1'b1, 1'b1, "abc_b2b");
        expect_digest(0, H_ABC, 0, "abc_b2b");

        for (int d = 0; d < N; d++) begin
            build("abc");
            accept(d, msg_q[0], 1'b1, 1'b1, "abc");
            expect_digest(d, H_ABC, 1, "abc");
            build("12345678901234567890123456789012345678901234567890123456789012345678901234567890");
            accept(d, msg_q[0], 1'b1, 1'b0, "dig80_b0");
            expect_mid(d, "dig80_b0");
            accept(d, msg_q[1], 1'b0, 1'b1, "dig80_b1");
            expect_digest(d, H_DIG80, 2, "dig80");
        end

        // Reset at step 30 of a block, then "abc" with first=0 must still start from IV.
        accept(0, rand_blk(), 1'b1, 1'b1, "abort");
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 128'(out_valid[0]), 128'(0));
        check("abort busy", 128'(busy[0]), 128'(0));
        check("abort hash", hash[0], 128'(0));
        check("abort in_ready", 128'(in_ready[0]), 128'(1));
        for (int d = 0; d < N; d++) chain_m[d] = IV_M;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        build("abc");
        accept(0, msg_q[0], 1'b0, 1'b1, "abc_after_rst");
        expect_digest(0, H_ABC, 0, "abc_after_rst");

        // Random 1-3 block messages; first on the opening block is random so chains continue.
        for (int d = 0; d < N; d++) begin
            for (int m = 0; m < 5; m++) begin
                msg_q.delete();
                nb = $urandom_range(1, 3);
                for (int i = 0; i < nb; i++) msg_q.push_back(rand_blk());
                send_msg(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
